// File: rtl/modexp_ladder_if.sv
// Request/response bundle for the modular exponentiator.
interface modexp_ladder_if #(
  parameter int unsigned W  = 2048,
  parameter int unsigned EW = 2048
) ();
  logic          start;
  logic          ct_mode;
  logic [W-1:0]  m;
  logic [EW-1:0] e;
  logic [W-1:0]  n;
  logic          ready;
  logic          done;
  logic [W-1:0]  c;

  modport master (output start, ct_mode, m, e, n, input ready, done, c);
  modport slave  (input start, ct_mode, m, e, n, output ready, done, c);
endinterface

// File: rtl/modexp_ladder.sv
// Modular exponentiator c = m^e mod n: fast square-and-multiply or
// constant-time Montgomery ladder, built on two bit-serial modmul units.

// Interleaved bit-serial modular multiplier, p = a*b mod n, W cycles per product.
module modexp_ladder_modmul #(
  parameter int unsigned W = 2048
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic         ready,
  output logic [W-1:0] p
);
  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  acc, a_q, b_q, n_q;
  logic [CW-1:0] cnt;
  logic [W:0]    dbl_c, dbl_red_c, sum_c, sum_red_c;

  // One MSB-first step: acc = 2*acc + b_bit*a, each partial reduced once (acc, a < n).
  always_comb begin
    dbl_c     = {acc, 1'b0};
    dbl_red_c = (dbl_c >= {1'b0, n_q}) ? dbl_c - {1'b0, n_q} : dbl_c;
    sum_c     = dbl_red_c + (b_q[W-1] ? {1'b0, a_q} : (W + 1)'(0));
    sum_red_c = (sum_c >= {1'b0, n_q}) ? sum_c - {1'b0, n_q} : sum_c;
  end

  // Accept a start while ready, then iterate over the W bits of b.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready <= 1'b1;
      p     <= '0;
      acc   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      n_q   <= '0;
      cnt   <= '0;
    end else if (ready) begin
      if (start) begin
        a_q   <= a;
        b_q   <= b;
        n_q   <= n;
        acc   <= '0;
        cnt   <= CW'(W);
        ready <= 1'b0;
      end
    end else begin
      acc <= sum_red_c[W-1:0];
      b_q <= b_q << 1;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        ready <= 1'b1;
        p     <= sum_red_c[W-1:0];
      end
    end
  end
endmodule

module modexp_ladder #(
  parameter int unsigned W  = 2048,
  parameter int unsigned EW = 2048
) (
  input  logic            clk,
  input  logic            rst,
  modexp_ladder_if.slave  bus
);
  localparam int unsigned IW = $clog2(EW);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SCAN, S_SQ, S_SQW, S_MUL, S_MULW,
    S_NEXT, S_LADDER, S_LADW, S_FIN, S_DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  m_q, n_q, r0, r1, c_q;
  logic [EW-1:0] e_q;
  logic          ct_q, ready_q, done_q;
  logic [IW-1:0] i;

  logic          sq_start_c, mul_start_c, sq_ready, mul_ready;
  logic [W-1:0]  sq_op_c, mul_a_c, mul_b_c, sq_p, mul_p;

  // Multiplier operand routing; starts are pulsed from the issuing state itself.
  always_comb begin
    sq_start_c  = (state == S_SQ) || (state == S_LADDER);
    mul_start_c = (state == S_MUL) || (state == S_LADDER);
    sq_op_c     = r0;
    if (state == S_LADDER && e_q[i]) sq_op_c = r1;
    mul_a_c     = r0;
    mul_b_c     = (state == S_LADDER) ? r1 : m_q;
  end

  modexp_ladder_modmul #(.W(W)) u_sq (
    .clk(clk), .rst(rst), .start(sq_start_c), .a(sq_op_c), .b(sq_op_c),
    .n(n_q), .ready(sq_ready), .p(sq_p)
  );

  modexp_ladder_modmul #(.W(W)) u_mul (
    .clk(clk), .rst(rst), .start(mul_start_c), .a(mul_a_c), .b(mul_b_c),
    .n(n_q), .ready(mul_ready), .p(mul_p)
  );

  // Control FSM with registered ready/done/c.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      c_q     <= '0;
      r0      <= '0;
      r1      <= '0;
      i       <= IW'(EW - 1);
      m_q     <= '0;
      n_q     <= '0;
      e_q     <= '0;
      ct_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          m_q     <= bus.m;
          e_q     <= bus.e;
          n_q     <= bus.n;
          ct_q    <= bus.ct_mode;
          i       <= IW'(EW - 1);
          ready_q <= 1'b0;
          state   <= S_LOAD;
        end
        S_LOAD: begin
          if (e_q == '0) begin
            c_q    <= W'(1);
            done_q <= 1'b1;
            state  <= S_DONE;
          end else if (m_q == '0) begin
            c_q    <= '0;
            done_q <= 1'b1;
            state  <= S_DONE;
          end else if (ct_q) begin
            r0    <= W'(1);
            r1    <= m_q;
            state <= S_LADDER;
          end else begin
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (e_q[i]) begin
            r0 <= m_q;
            if (i == '0) state <= S_FIN;
            else begin
              i     <= i - IW'(1);
              state <= S_SQ;
            end
          end else if (i != '0) begin
            i <= i - IW'(1);
          end
        end
        S_SQ:  state <= S_SQW;
        S_SQW: if (sq_ready) begin
          r0    <= sq_p;
          state <= e_q[i] ? S_MUL : S_NEXT;
        end
        S_MUL:  state <= S_MULW;
        S_MULW: if (mul_ready) begin
          r0    <= mul_p;
          state <= S_NEXT;
        end
        S_NEXT: begin
          if (i == '0) state <= S_FIN;
          else begin
            i     <= i - IW'(1);
            state <= ct_q ? S_LADDER : S_SQ;
          end
        end
        S_LADDER: state <= S_LADW;
        S_LADW: if (sq_ready && mul_ready) begin
          if (e_q[i]) begin
            r0 <= mul_p;
            r1 <= sq_p;
          end else begin
            r1 <= mul_p;
            r0 <= sq_p;
          end
          state <= S_NEXT;
        end
        S_FIN: begin
          c_q    <= r0;
          done_q <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.c     = c_q;
endmodule
